// File: rtl/cavlc_nal_byte_writer_if.sv
// Bundle of every non-clock signal at the CAVLC NAL byte writer.
//   master : packer/sink side. Drives write strobes, packed bytes, NAL start/header
//            and m_ready. Observes flow control, the byte stream and status.
//   slave  : the byte writer itself.
// Signals:
//   we, codebit[83:0], tmpAddr[3:0]  : burst of completed bytes from the bit packer
//   trail_we, rbsp_trailing[7:0]     : NAL-terminating RBSP trailing byte
//   nal_start, nal_hdr[7:0]          : begin a NAL with this header byte
//   in_ready                         : room for a full 11-byte burst
//   m_valid, m_data[7:0], m_last,
//   m_ready                          : output byte stream handshake
//   busy, fifo_level[AW:0], ovf_err  : status
interface cavlc_nal_byte_writer_if #(
    parameter int AW = 5
);
    logic          we;
    logic [83:0]   codebit;
    logic [3:0]    tmpAddr;
    logic          trail_we;
    logic [7:0]    rbsp_trailing;
    logic          nal_start;
    logic [7:0]    nal_hdr;
    logic          in_ready;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic [AW:0]   fifo_level;
    logic          ovf_err;

    modport master (
        output we, codebit, tmpAddr, trail_we, rbsp_trailing, nal_start, nal_hdr, m_ready,
        input  in_ready, m_valid, m_data, m_last, busy, fifo_level, ovf_err
    );

    modport slave (
        input  we, codebit, tmpAddr, trail_we, rbsp_trailing, nal_start, nal_hdr, m_ready,
        output in_ready, m_valid, m_data, m_last, busy, fifo_level, ovf_err
    );
endinterface

// File: rtl/cavlc_nal_byte_writer.sv
// CAVLC NAL byte writer: buffers up to 11 bytes per cycle from the bit packer in a
// byte FIFO and drains it one byte per handshake. Each NAL is prefixed with the
// 00 00 00 01 start code and the header byte. Emulation-prevention bytes (0x03)
// are inserted into the payload.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cavlc_nal_byte_writer_if.slave (write burst, NAL start, output stream, status)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no NAL in progress; waits for nal_start while not busy
// SC     | emitting start code / header; sc_cnt indexes the next byte (1..4)
// DATA   | emitting FIFO bytes, tracking consecutive zeros
// EPB    | 0x03 already issued; FIFO head goes out next without the zero check
module cavlc_nal_byte_writer #(
    parameter int FIFO_DEPTH = 32,
    parameter int AW         = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cavlc_nal_byte_writer_if.slave bus
);
    localparam int            MAX_PUSH = 11;
    localparam logic [AW:0]   LVL_MAX  = (AW+1)'(FIFO_DEPTH - MAX_PUSH);

    typedef enum logic [1:0] {S_IDLE, S_SC, S_DATA, S_EPB} state_t;

    state_t       state, state_n;
    logic [8:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  level;
    logic [7:0]   hdr_q;
    logic [2:0]   sc_cnt, sc_cnt_n;
    logic [1:0]   zero_cnt, zero_cnt_n;
    logic         m_valid_q, m_last_q, ovf_q;
    logic [7:0]   m_data_q;

    logic         in_ready, wr_req, wr_ok, busy, load, empty, epb_hit, pop;
    logic         emit, emit_last;
    logic [7:0]   emit_data;
    logic [3:0]   n_we, n_push;
    logic [7:0]   cb_byte  [MAX_PUSH];
    logic [8:0]   push_ent [MAX_PUSH];
    logic [8:0]   head;

    // Write side: up to 10 packer bytes plus the trailing byte in one cycle.
    for (genvar k = 0; k < 10; k++) begin : g_cb
        assign cb_byte[k] = bus.codebit[83-8*k -: 8];
    end
    assign cb_byte[10] = 8'h00;

    assign in_ready = (level <= LVL_MAX);
    assign wr_req   = bus.we | bus.trail_we;
    assign wr_ok    = wr_req & in_ready;
    assign n_we     = !bus.we ? 4'd0 : (bus.tmpAddr > 4'd10) ? 4'd10 : bus.tmpAddr;
    assign n_push   = wr_ok ? (n_we + {3'b000, bus.trail_we}) : 4'd0;

    // Slot n_we holds the trailing byte; slots beyond n_push are never written.
    always_comb begin
        for (int i = 0; i < MAX_PUSH; i++) begin
            push_ent[i] = (4'(i) < n_we) ? {1'b0, cb_byte[i]} : {1'b1, bus.rbsp_trailing};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_PUSH; i++) begin
            if (4'(i) < n_push) mem[wr_ptr + AW'(i)] <= push_ent[i];
        end
    end

    assign head    = mem[rd_ptr];
    assign empty   = (level == '0);
    assign load    = !m_valid_q || bus.m_ready;
    assign busy    = (state != S_IDLE) || !empty || m_valid_q;
    assign epb_hit = (zero_cnt == 2'd2) && (head[7:0] <= 8'h03);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // FSM next state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.nal_start && !busy) state_n = S_SC;
            S_SC:   if (load && sc_cnt == 3'd4) state_n = S_DATA;
            S_DATA: if (load && !empty) begin
                if (epb_hit)      state_n = S_EPB;
                else if (head[8]) state_n = S_IDLE;
            end
            S_EPB:  if (load && !empty) state_n = head[8] ? S_IDLE : S_DATA;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM outputs. The first start-code byte is issued from IDLE so it is
    // valid the cycle after nal_start.
    always_comb begin
        emit       = 1'b0;
        emit_data  = 8'h00;
        emit_last  = 1'b0;
        pop        = 1'b0;
        sc_cnt_n   = sc_cnt;
        zero_cnt_n = zero_cnt;
        case (state)
            S_IDLE: if (bus.nal_start && !busy) begin
                emit     = 1'b1;
                sc_cnt_n = 3'd1;
            end
            S_SC: if (load) begin
                emit      = 1'b1;
                emit_data = (sc_cnt == 3'd3) ? 8'h01 : (sc_cnt == 3'd4) ? hdr_q : 8'h00;
                sc_cnt_n  = (sc_cnt == 3'd4) ? 3'd0 : sc_cnt + 3'd1;
                if (sc_cnt == 3'd4) zero_cnt_n = 2'd0;
            end
            S_DATA: if (load && !empty) begin
                emit = 1'b1;
                if (epb_hit) begin
                    emit_data  = 8'h03;
                    zero_cnt_n = 2'd0;
                end else begin
                    emit_data  = head[7:0];
                    emit_last  = head[8];
                    pop        = 1'b1;
                    zero_cnt_n = (head[7:0] != 8'h00) ? 2'd0 :
                                 (zero_cnt == 2'd2)   ? 2'd2 : zero_cnt + 2'd1;
                end
            end
            S_EPB: if (load && !empty) begin
                emit       = 1'b1;
                emit_data  = head[7:0];
                emit_last  = head[8];
                pop        = 1'b1;
                zero_cnt_n = (head[7:0] == 8'h00) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            hdr_q     <= 8'h00;
            sc_cnt    <= 3'd0;
            zero_cnt  <= 2'd0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(n_push);
            rd_ptr   <= rd_ptr + AW'(pop);
            level    <= level + (AW+1)'(n_push) - (AW+1)'(pop);
            sc_cnt   <= sc_cnt_n;
            zero_cnt <= zero_cnt_n;
            if (state == S_IDLE && bus.nal_start && !busy) hdr_q <= bus.nal_hdr;
            if (wr_req && !in_ready) ovf_q <= 1'b1;
            if (load) begin
                m_valid_q <= emit;
                if (emit) begin
                    m_data_q <= emit_data;
                    m_last_q <= emit_last;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
    assign bus.busy       = busy;
    assign bus.fifo_level = level;
    assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_cavlc_nal_byte_writer.sv
// Testbench for cavlc_nal_byte_writer. Directed NALs plus randomized payloads and
// random m_ready back-pressure. Received bytes are compared against an emulation-
// prevention reference model built from the payload byte list.
module tb_cavlc_nal_byte_writer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rcv_q[$];
    logic [7:0] pl_q[$];
    bit         rand_rdy = 1'b0;
    bit         rdy_fixed = 1'b1;
    logic       stall_q = 1'b0;
    logic [8:0] held_q = '0;

    always #5 clk = ~clk;

    cavlc_nal_byte_writer_if #(.AW(5)) bus();
    cavlc_nal_byte_writer #(.FIFO_DEPTH(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sink back-pressure
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Monitor: capture accepted bytes, verify hold during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) chk("hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, held_q});
            if (bus.m_valid && bus.m_ready) rcv_q.push_back({bus.m_last, bus.m_data});
            stall_q = bus.m_valid && !bus.m_ready;
            held_q  = {bus.m_last, bus.m_data};
        end
    end

    task automatic wait_idle(input string tag);
        int budget = 0;
        while (bus.busy && budget < 5000) begin step(); budget++; end
        chk(tag, bus.busy, 0);
    endtask

    task automatic start_nal(input logic [7:0] hdr, input bit chk_lat);
        wait_idle("pre_start_idle");
        bus.nal_start = 1'b1;
        bus.nal_hdr   = hdr;
        @(negedge clk);
        if (chk_lat) chk("lat_pre", bus.m_valid, 0);
        @(posedge clk);
        #1;
        bus.nal_start = 1'b0;
        if (chk_lat) chk("lat_sc0", {bus.m_valid, bus.m_data}, {1'b1, 8'h00});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h001);
        exp_q.push_back({1'b0, hdr});
    endtask

    task automatic write_chunk(input int base, input int n, input bit tr, input logic [7:0] trail,
                               input bit wait_rdy, input bit stray_start);
        logic [95:0] r96;
        logic [83:0] cb;
        int budget = 0;
        if (wait_rdy) begin
            while (!bus.in_ready && budget < 1000) begin step(); budget++; end
            if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        end
        r96 = {$urandom, $urandom, $urandom};
        cb  = r96[83:0];
        for (int k = 0; k < n; k++) cb[83-8*k -: 8] = pl_q[base+k];
        bus.codebit       = cb;
        bus.we            = (n > 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.tmpAddr       = (n == 10) ? 4'($urandom_range(10, 15)) :
                            (bus.we)  ? 4'(n) : 4'($urandom_range(0, 15));
        bus.trail_we      = tr;
        bus.rbsp_trailing = trail;
        bus.nal_start     = stray_start;
        bus.nal_hdr       = 8'($urandom);
        step();
        bus.we        = 1'b0;
        bus.trail_we  = 1'b0;
        bus.nal_start = 1'b0;
    endtask

    // Reference: H.264 emulation prevention over payload followed by the trailing byte.
    task automatic expect_body(input logic [7:0] trail);
        logic [7:0] seq[$];
        int z = 0;
        seq = pl_q;
        seq.push_back(trail);
        for (int i = 0; i < seq.size(); i++) begin
            if (z >= 2 && seq[i] <= 8'h03) begin
                exp_q.push_back(9'h003);
                z = 0;
            end
            exp_q.push_back({(i == seq.size() - 1), seq[i]});
            z = (seq[i] == 8'h00) ? z + 1 : 0;
        end
    endtask

    task automatic check_stream(input string tag);
        int budget = 0;
        while (rcv_q.size() < exp_q.size() && budget < 5000) begin step(); budget++; end
        wait_idle({tag, "_idle"});
        repeat (3) step();
        chk({tag, "_len"}, rcv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rcv_q.size()) chk(tag, rcv_q[i], exp_q[i]);
        exp_q.delete();
        rcv_q.delete();
        pl_q.delete();
    endtask

    task automatic send_nal(input logic [7:0] hdr, input logic [7:0] trail,
                            input int min_chunk, input int max_chunk, input bit chk_lat);
        int idx = 0;
        int rem, n;
        bit last;
        start_nal(hdr, chk_lat);
        forever begin
            rem  = pl_q.size() - idx;
            n    = $urandom_range(min_chunk, max_chunk);
            if (n > rem) n = rem;
            last = (n == rem);
            write_chunk(idx, n, last, trail, 1'b1, !last && ($urandom_range(0, 3) == 0));
            idx += n;
            if (last) break;
        end
        expect_body(trail);
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 9);
        if (r < 5) return 8'h00;
        if (r < 8) return 8'($urandom_range(1, 3));
        return 8'($urandom_range(4, 255));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.we            = 1'b0;
        bus.codebit       = '0;
        bus.tmpAddr       = '0;
        bus.trail_we      = 1'b0;
        bus.rbsp_trailing = '0;
        bus.nal_start     = 1'b0;
        bus.nal_hdr       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        step();

        // Basic NAL: 00 00 00 01 65 AB CD EF 80, single write of 3 bytes + trail
        pl_q = '{8'hAB, 8'hCD, 8'hEF};
        send_nal(8'h65, 8'h80, 10, 10, 1'b1);
        check_stream("basic");

        pl_q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        send_nal(8'h41, 8'h80, 0, 10, 1'b0);
        check_stream("epb_two");

        pl_q = '{8'h00, 8'h00, 8'h04};
        send_nal(8'h41, 8'h80, 0, 10, 1'b0);
        check_stream("no_epb");

        pl_q = '{8'h00, 8'h00};
        send_nal(8'h25, 8'h01, 0, 10, 1'b0);
        check_stream("epb_trail");

        // Random back-pressure and payloads
        rand_rdy = 1'b1;
        for (int nal = 0; nal < 10; nal++) begin
            int len = $urandom_range(15, 40);
            for (int i = 0; i < len; i++) pl_q.push_back(rand_byte());
            send_nal(8'($urandom), ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom_range(1, 255)),
                     0, 10, 1'b1);
            check_stream("rand");
        end

        // Overflow: sink stalled, three 10-byte bursts fill to 30, fourth is dropped
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b0;
        repeat (2) step();
        start_nal(8'h06, 1'b0);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 10; i++) pl_q.push_back(rand_byte());
            write_chunk(10*j, 10, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("ovf_level", bus.fifo_level, 10*(j+1));
            chk("ovf_in_ready", bus.in_ready, (j < 2) ? 1 : 0);
            chk("ovf_clear", bus.ovf_err, 0);
        end
        for (int i = 0; i < 10; i++) pl_q.push_back(8'($urandom));
        write_chunk(30, 10, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (10) void'(pl_q.pop_back());
        chk("ovf_set", bus.ovf_err, 1);
        chk("ovf_level_kept", bus.fifo_level, 30);
        rand_rdy = 1'b1;
        write_chunk(30, 0, 1'b1, 8'h80, 1'b1, 1'b0);
        expect_body(8'h80);
        check_stream("ovf_contents");
        chk("ovf_sticky", bus.ovf_err, 1);

        // Reset in the middle of a NAL
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        repeat (2) step();
        start_nal(8'h67, 1'b0);
        for (int i = 0; i < 8; i++) pl_q.push_back(8'($urandom_range(4, 255)));
        write_chunk(0, 8, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_m_data", bus.m_data, 0);
        chk("mid_rst_m_last", bus.m_last, 0);
        chk("mid_rst_ovf", bus.ovf_err, 0);
        chk("mid_rst_level", bus.fifo_level, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        step();
        exp_q.delete();
        rcv_q.delete();
        pl_q.delete();
        for (int i = 0; i < 5; i++) pl_q.push_back(rand_byte());
        send_nal(8'h65, 8'h80, 0, 10, 1'b1);
        check_stream("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
